// File: rtl/count_seq_checker.sv
// Monitor for a free-running modulo-2^WIDTH counter: acquires lock on a clean
// +1 sequence, then flags mismatches, counts wraps and reports loss of lock.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int SYNC_LEN = 3,
    parameter int LOST_LEN = 2,
    parameter int CNTW     = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] q,
    input  logic             sample,
    output logic             locked,
    output logic             mismatch,
    output logic             lost_seen,
    output logic [CNTW-1:0]  err_count,
    output logic [CNTW-1:0]  wrap_count,
    output logic [WIDTH-1:0] last_q
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;
    localparam logic [1:0] ST_LOST = 2'd3;

    localparam int GW = (SYNC_LEN < 1) ? 1 : $clog2(SYNC_LEN + 1);
    localparam int BW = (LOST_LEN < 1) ? 1 : $clog2(LOST_LEN + 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             lost_seen_q, lost_seen_d;
    logic [CNTW-1:0]  err_q, err_d;
    logic [CNTW-1:0]  wrap_q, wrap_d;

    logic [WIDTH-1:0] expected;
    logic [GW-1:0]    good_inc;
    logic [BW-1:0]    bad_inc;

    assign expected = prev_q + 1'b1;
    assign good_inc = good_q + 1'b1;
    assign bad_inc  = bad_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_d      = good_q;
        bad_d       = bad_q;
        mismatch_d  = 1'b0;
        lost_seen_d = lost_seen_q;
        err_d       = err_q;
        wrap_d      = wrap_q;

        if (sample) begin
            // Always re-base on the observed value so one skip costs one mismatch.
            prev_d = q;
            case (state_q)
                ST_SYNC: begin
                    if (q == expected) begin
                        if (good_inc == GW'(SYNC_LEN)) begin
                            state_d = ST_LOCK;
                            bad_d   = '0;
                            good_d  = '0;
                        end else begin
                            good_d = good_inc;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCK: begin
                    if (q == expected) begin
                        bad_d = '0;
                        if (prev_q == {WIDTH{1'b1}} && wrap_q != {CNTW{1'b1}}) begin
                            wrap_d = wrap_q + 1'b1;
                        end
                    end else begin
                        mismatch_d = 1'b1;
                        if (err_q != {CNTW{1'b1}}) begin
                            err_d = err_q + 1'b1;
                        end
                        if (bad_inc == BW'(LOST_LEN)) begin
                            state_d     = ST_LOST;
                            bad_d       = '0;
                            lost_seen_d = 1'b1;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
                default: begin
                    // IDLE and LOST both just capture a new base value.
                    state_d = ST_SYNC;
                    good_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            lost_seen_q <= 1'b0;
            err_q       <= '0;
            wrap_q      <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            mismatch_q  <= mismatch_d;
            lost_seen_q <= lost_seen_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
        end
    end

    assign locked     = locked_q;
    assign mismatch   = mismatch_q;
    assign lost_seen  = lost_seen_q;
    assign err_count  = err_q;
    assign wrap_count = wrap_q;
    assign last_q     = prev_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Randomised and directed bench for count_seq_checker; a default-width instance
// and a CNTW=2 instance share stimulus and are checked against one model.
module tb_count_seq_checker;

    localparam int WIDTH    = 4;
    localparam int SYNC_LEN = 3;
    localparam int LOST_LEN = 2;
    localparam int MODV     = 1 << WIDTH;

    logic             clock = 1'b0;
    logic             clear = 1'b1;
    logic [WIDTH-1:0] q = '0;
    logic             sample = 1'b0;

    logic             a_locked, a_mismatch, a_lost_seen;
    logic [7:0]       a_err, a_wrap;
    logic [WIDTH-1:0] a_last_q;
    logic             b_locked, b_mismatch, b_lost_seen;
    logic [1:0]       b_err, b_wrap;
    logic [WIDTH-1:0] b_last_q;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 idle/lost-equivalent rebase, 1 acquiring, 2 locked.
    int m_mode, m_prev, m_run, m_miss, m_err, m_wrap;
    bit m_locked, m_mis, m_lost;

    always #5 clock = ~clock;

    count_seq_checker #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .LOST_LEN(LOST_LEN), .CNTW(8)) dut_a (
        .clock(clock), .clear(clear), .q(q), .sample(sample),
        .locked(a_locked), .mismatch(a_mismatch), .lost_seen(a_lost_seen),
        .err_count(a_err), .wrap_count(a_wrap), .last_q(a_last_q)
    );

    count_seq_checker #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .LOST_LEN(LOST_LEN), .CNTW(2)) dut_b (
        .clock(clock), .clear(clear), .q(q), .sample(sample),
        .locked(b_locked), .mismatch(b_mismatch), .lost_seen(b_lost_seen),
        .err_count(b_err), .wrap_count(b_wrap), .last_q(b_last_q)
    );

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_run = 0; m_miss = 0; m_err = 0; m_wrap = 0;
        m_locked = 0; m_mis = 0; m_lost = 0;
    endtask

    task automatic model_step(input bit clr, input bit smp, input int qv);
        int exp_q;
        if (clr) begin
            model_reset();
            return;
        end
        m_mis = 0;
        if (!smp) return;
        exp_q = (m_prev + 1) % MODV;
        if (m_mode == 0) begin
            m_mode = 1;
            m_run  = 0;
        end else if (m_mode == 1) begin
            m_run = (qv == exp_q) ? m_run + 1 : 0;
            if (m_run == SYNC_LEN) begin
                m_mode = 2;
                m_miss = 0;
            end
        end else begin
            if (qv == exp_q) begin
                m_miss = 0;
                if (m_prev == MODV - 1) m_wrap++;
            end else begin
                m_mis = 1;
                m_err++;
                m_miss++;
                if (m_miss == LOST_LEN) begin
                    m_mode = 0;
                    m_lost = 1;
                end
            end
        end
        m_prev   = qv;
        m_locked = (m_mode == 2);
    endtask

    task automatic compare_all();
        chk("a_locked",   a_locked,    m_locked);
        chk("a_mismatch", a_mismatch,  m_mis);
        chk("a_lost",     a_lost_seen, m_lost);
        chk("a_err",      a_err,       sat(m_err, 255));
        chk("a_wrap",     a_wrap,      sat(m_wrap, 255));
        chk("a_last_q",   a_last_q,    m_prev);
        chk("b_locked",   b_locked,    m_locked);
        chk("b_mismatch", b_mismatch,  m_mis);
        chk("b_err",      b_err,       sat(m_err, 3));
        chk("b_wrap",     b_wrap,      sat(m_wrap, 3));
        chk("b_last_q",   b_last_q,    m_prev);
    endtask

    // One clock of stimulus; outputs are checked 1 time unit after the edge.
    task automatic step(input bit clr, input bit smp, input int qv);
        clear  = clr;
        sample = smp;
        q      = qv[WIDTH-1:0];
        model_step(clr, smp, qv % MODV);
        @(posedge clock);
        #1;
        compare_all();
        $display("txn clr=%0d smp=%0d q=%0d -> locked=%0d mis=%0d lost=%0d err=%0d/%0d wrap=%0d last_q=%0d",
                 clr, smp, qv % MODV, a_locked, a_mismatch, a_lost_seen, a_err, b_err, a_wrap, a_last_q);
    endtask

    task automatic samp(input int qv);
        step(1'b0, 1'b1, qv);
    endtask

    initial begin
        int qv;
        int r;
        model_reset();
        #1;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 5);
        chk("rst_locked", a_locked, 0);
        chk("rst_last_q", a_last_q, 0);
        chk("rst_err", a_err, 0);

        // Lock acquisition
        samp(0); samp(1); samp(2);
        chk("acq_not_yet", a_locked, 0);
        samp(3);
        chk("acq_locked", a_locked, 1);
        chk("acq_err", a_err, 0);

        // Wrap while locked
        for (int i = 4; i <= 12; i++) samp(i);
        samp(13); samp(14); samp(15); samp(0); samp(1);
        chk("wrap_count", a_wrap, 1);
        chk("wrap_locked", a_locked, 1);

        // Single skip
        samp(2); samp(3); samp(4); samp(5); samp(6);
        samp(9);
        chk("skip_pulse", a_mismatch, 1);
        samp(10);
        chk("skip_pulse_gone", a_mismatch, 0);
        samp(11);
        chk("skip_err", a_err, 1);
        chk("skip_last_q", a_last_q, 11);
        chk("skip_locked", a_locked, 1);

        // Second isolated skip, then clear with simultaneous sample
        samp(13); samp(14);
        chk("err_two", a_err, 2);
        step(1'b1, 1'b1, 7);
        chk("clr_locked", a_locked, 0);
        chk("clr_err", a_err, 0);
        chk("clr_last_q", a_last_q, 0);
        samp(7); samp(8); samp(9);
        chk("reacq_not_yet", a_locked, 0);
        samp(10);
        chk("reacq_locked", a_locked, 1);

        // Lock loss then relock
        for (int i = 11; i <= 22; i++) samp(i % MODV);
        samp(9);
        samp(3);
        chk("loss_err", a_err, 2);
        chk("loss_locked", a_locked, 0);
        chk("loss_lost", a_lost_seen, 1);
        chk("loss_wrap", a_wrap, 1);
        samp(4); samp(5); samp(6);
        chk("relock_not_yet", a_locked, 0);
        samp(7);
        chk("relock_locked", a_locked, 1);
        chk("relock_lost", a_lost_seen, 1);

        // Sample gating
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, $urandom_range(0, MODV - 1));
        chk("gate_last_q", a_last_q, 7);
        chk("gate_locked", a_locked, 1);

        // Five isolated mismatches: CNTW=2 instance saturates
        qv = 7;
        for (int i = 0; i < 5; i++) begin
            qv = (qv + 2) % MODV; samp(qv);
            qv = (qv + 1) % MODV; samp(qv);
        end
        chk("sat_b_err", b_err, 3);
        chk("sat_a_err", a_err, 7);
        chk("sat_locked", a_locked, 1);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(1'b1, $urandom_range(0, 1), $urandom_range(0, MODV - 1));
            end else if (r < 25) begin
                step(1'b0, 1'b0, $urandom_range(0, MODV - 1));
            end else if (r < 35) begin
                samp($urandom_range(0, MODV - 1));
            end else begin
                samp((m_prev + 1) % MODV);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side companion to the 4-bit `counter`: samples a free-running counter value `q` and checks that it advances by exactly +1 modulo 2^WIDTH on every qualified sample.
- Acquires lock, then reports mismatches, wrap-arounds and loss of lock.
- Sits downstream of any counter instance as a self-checking monitor, both in system builds and in benches.

Parameters:
WIDTH, 4, width of observed count value
SYNC_LEN, 3, consecutive correct increments required to declare lock
LOST_LEN, 2, consecutive mismatches while locked that drop lock
CNTW, 8, width of err_count and wrap_count (saturating)

Ports:
clock  input  1  single system clock, all state updates on rising edge
clear  input  1  synchronous, active-high reset; priority over all other inputs
q  input  WIDTH  observed counter value
sample  input  1  q is valid this cycle; q is ignored when low
locked  output  1  checker is in LOCK state
mismatch  output  1  one-cycle pulse: sampled q != expected while locked
lost_seen  output  1  sticky: lock has been lost at least once since clear
err_count  output  CNTW  number of mismatches while locked, saturates at all-ones
wrap_count  output  CNTW  number of all-ones to 0 transitions seen while locked, saturates
last_q  output  WIDTH  last sampled q

Behaviour:
- All outputs are registered.
- An event sampled at rising edge N is visible after edge N; mismatch is high for exactly that one cycle.
- Reset on clear=1 at an edge:
  - state=IDLE.
  - locked=0, mismatch=0, lost_seen=0, err_count=0, wrap_count=0, last_q=0.
  - Internal good/bad run counters are 0.
  - clear overrides a simultaneous sample.
  - clear mid-lock discards all history.
- Internal prev register holds the last sampled q; last_q mirrors it. expected = prev+1, truncated to WIDTH bits, so all-ones wraps to 0.
- sample=0: no state, counter or output change, except that mismatch returns to 0.
- States and transitions (each applies only on edges with sample=1):
  - IDLE: prev<=q; go to SYNC with good=0.
  - SYNC, q==expected: good++; when good reaches SYNC_LEN, go to LOCK with bad=0.
  - SYNC, q!=expected: good<=0; stay in SYNC. No mismatch pulse, no err_count change.
  - LOCK, q==expected: bad<=0. If prev==all-ones and q==0, wrap_count++ (saturating).
  - LOCK, q!=expected: mismatch=1 for one cycle; err_count++ (saturating); bad++. When bad reaches LOST_LEN, go to LOST and set lost_seen=1.
  - LOST: locked=0. The next sample captures q into prev and goes to SYNC with good=0, i.e. behaves like IDLE.
- prev<=q on every sampled edge in every state, so the checker re-bases on erroneous values: a single skip produces exactly one mismatch.
- locked=1 exactly while state==LOCK. The first sampled edge after lock is already checked.
- Saturation: err_count and wrap_count hold at 2^CNTW-1 and never wrap.
- Width rule: comparison is on WIDTH bits only; no sign handling.
- Minimum lock latency after clear is SYNC_LEN+1 sampled edges.

Test Plan:
- Lock acquisition (defaults): clear, then sample q=0,1,2,3 on consecutive cycles -> locked rises after the edge sampling 3; before that locked=0; mismatch never pulses; err_count=0.
- Wrap: locked, then sample 13,14,15,0,1 -> wrap_count=1, mismatch stays 0, locked stays 1.
- Single skip: locked at 5, sample 6,9,10,11 -> one mismatch pulse on the cycle after 9 is sampled; err_count=1; locked stays 1; last_q=11.
- Lock loss and relock: locked, sample 6,9,3 -> two mismatch pulses, err_count=2, locked=0, lost_seen=1. Then sample 4,5,6,7 -> locked=1 again, lost_seen remains 1.
- Sample gating and saturation: while locked, hold sample=0 and drive random q for 10 cycles -> no output change. With CNTW=2, five isolated mismatches -> err_count saturates at 3.
- Clear mid-operation: while locked with err_count=2, assert clear with sample=1 and q=7 -> next cycle all outputs 0, state IDLE; the next sample of 7 starts a new acquisition.
